// File: rtl/ram_access_unit.sv
// ram_access_unit
// Processor-side initiator for a zero-delay, byte-addressed RAM. It accepts
// one load or store at a time, returns sign/zero-extended load data, and
// performs sub-word stores as read-modify-write. The RAM always writes a
// full 4-byte big-endian word starting at the given byte address.
//
// Ports
//   clock            sole clock, posedge
//   reset            asynchronous, active-low
//   req              request strobe (sampled only while idle)
//   reqWrite         1 = store, 0 = load
//   reqSize          00 byte, 01 half, 10 word, 11 illegal
//   reqSigned        loads: 1 = sign-extend, 0 = zero-extend
//   reqAddr          byte address (unaligned allowed)
//   reqData          right-justified store data
//   busy             high while not idle
//   done             one-cycle completion pulse
//   fault            valid with done; request rejected, no write performed
//   loadData         formatted load result
//   RAMAddr          address to RAM
//   RAMDataOut       word to RAM
//   RAMWriteControl  registered RAM write enable
//   RAMIn            combinational RAM read word (addr byte in [31:24])
module ram_access_unit #(
  parameter int dataW       = 32,
  parameter int RAMAddrSize = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   reqWrite,
  input  logic [1:0]             reqSize,
  input  logic                   reqSigned,
  input  logic [RAMAddrSize-1:0] reqAddr,
  input  logic [dataW-1:0]       reqData,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [dataW-1:0]       loadData,
  output logic [RAMAddrSize-1:0] RAMAddr,
  output logic [dataW-1:0]       RAMDataOut,
  output logic                   RAMWriteControl,
  input  logic [dataW-1:0]       RAMIn
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // Highest address whose 4-byte window still fits: RAM_MAX-3 = 2^N-4.
  localparam logic [RAMAddrSize-1:0] LC_LAST_OK = {{(RAMAddrSize-2){1'b1}}, 2'b00};

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_fault;
  logic                   r_write;
  logic [1:0]             r_size;
  logic                   r_signed;
  logic [dataW-1:0]       r_data;
  logic                   w_accept;
  logic                   w_req_fault;

  function automatic logic [31:0] f_format_load(input logic [1:0] size,
                                                input logic sgn,
                                                input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = $signed(word[31:24]);
    h = $signed(word[31:16]);
    case (size)
      2'b00:   f_format_load = sgn ? {{24{b[7]}}, b}  : {24'b0, b};
      2'b01:   f_format_load = sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: f_format_load = word;
    endcase
  endfunction

  // Only the addressed bytes take new data; the rest are written back as read.
  function automatic logic [31:0] f_merge_store(input logic [1:0] size,
                                                input logic [31:0] data,
                                                input logic [31:0] word);
    case (size)
      2'b00:   f_merge_store = {data[7:0], word[23:0]};
      2'b01:   f_merge_store = {data[15:0], word[15:0]};
      default: f_merge_store = data;
    endcase
  endfunction

  assign w_accept    = (r_state == IDLE) && req;
  assign w_req_fault = (reqSize == 2'b11) || (reqAddr > LC_LAST_OK);

  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    done   = (r_state == RESP);
    fault  = (r_state == RESP) && r_fault;
    case (r_state)
      IDLE: begin
        if (req) begin
          if (w_req_fault)                         w_next = RESP;
          else if (reqWrite && reqSize == 2'b10)   w_next = WRITE;
          else                                     w_next = READ;
        end
      end
      READ:    w_next = r_write ? WRITE : RESP;
      WRITE:   w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_fault         <= 1'b0;
      loadData        <= '0;
      RAMAddr         <= '0;
      RAMDataOut      <= '0;
      RAMWriteControl <= 1'b0;
    end else begin
      r_state         <= w_next;
      // Enable is registered so it is high for exactly the WRITE cycle.
      RAMWriteControl <= (w_next == WRITE);
      if (w_accept) begin
        RAMAddr <= reqAddr;
        r_fault <= w_req_fault;
        if (w_next == WRITE) RAMDataOut <= reqData;
      end
      if (r_state == READ) begin
        if (r_write) RAMDataOut <= f_merge_store(r_size, r_data, RAMIn);
        else         loadData   <= f_format_load(r_size, r_signed, RAMIn);
      end
    end
  end

  // Request fields are pure data: captured on accept, no reset needed.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_write  <= reqWrite;
      r_size   <= reqSize;
      r_signed <= reqSigned;
      r_data   <= reqData;
    end
  end

endmodule
